// File: rtl/buzzer_seq.sv
// buzzer_seq: melody sequencer and access arbiter for the buzzer tone generator.
// Live keypad notes always win the buzzer; otherwise a stored melody read from
// a small writable note table drives tone/unable, one note then a silent gap.
// Entry format {tone[6:5], note[4:2], len[1:0]}; tone==00 marks the end.
// Optional macro LOOP_EN: playback restarts at entry 0 on an end marker or
// index wrap and only play_stop ends it (an end marker at entry 0 still ends).
module buzzer_seq #(
   parameter int CLK_HZ   = 50000000,
   parameter int NOTE_MS  = 250,
   parameter int GAP_MS   = 20,
   parameter int SONG_LEN = 8,
   localparam int AW      = $clog2(SONG_LEN)
) (
   input  logic          sysclk,
   input  logic          rst,
   input  logic          key_valid,
   input  logic [2:0]    key_note,
   input  logic [1:0]    key_tone,
   input  logic          play_start,
   input  logic          play_stop,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [6:0]    cfg_data,
   output logic [1:0]    tone,
   output logic [2:0]    unable,
   output logic          busy,
   output logic          done
);

   localparam int TICK_DIV = CLK_HZ / 1000;
   localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int MS_MAX   = (4 * NOTE_MS > GAP_MS) ? 4 * NOTE_MS : GAP_MS;
   localparam int MW       = $clog2(MS_MAX) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_NOTE,
      S_GAP,
      S_PAUSE
   } state_t;

   typedef struct packed {
      logic [1:0] tone;
      logic [2:0] note;
      logic [1:0] len;
   } entry_t;

   state_t          state, state_d;
   logic [AW-1:0]   idx, idx_d;
   logic [TW-1:0]   tick_cnt;
   logic [MW-1:0]   ms_cnt;
   logic [MW-1:0]   ms_limit;
   entry_t          song_mem [SONG_LEN];
   entry_t          cur_entry;
   logic            counting;
   logic            tick;
   logic            phase_end;
   logic            clr_cnt;
   logic            done_d;
   logic [1:0]      tone_d;
   logic [2:0]      unable_d;

   assign cur_entry = song_mem[idx];
   assign counting  = (state == S_NOTE) || (state == S_GAP);
   assign tick      = counting && (tick_cnt == TW'(TICK_DIV - 1));
   assign ms_limit  = (state == S_GAP) ? MW'(GAP_MS)
                                       : MW'((int'(cur_entry.len) + 1) * NOTE_MS);
   assign phase_end = tick && (ms_cnt == ms_limit - MW'(1));

   // Note table: writable only while idle, cleared to end markers on reset.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         // NOTE: the table is reset because 0 is the end marker; a cleared table
         // must read as an empty song, so this storage is flops, not a RAM.
         for (int i = 0; i < SONG_LEN; i++) begin
            song_mem[i] <= '0;
         end
      end else if (state == S_IDLE && cfg_we) begin
         song_mem[cfg_addr] <= entry_t'(cfg_data);
      end
   end

   // State and index register.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         // NOTE: non-blocking assignments keep every register updating from
         // pre-edge values, independent of block ordering.
         state <= S_IDLE;
         idx   <= '0;
      end else begin
         state <= state_d;
         idx   <= idx_d;
      end
   end

   // 1 ms tick divider and ms counter; restart on every phase change, held in IDLE/PAUSE.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         tick_cnt <= '0;
         ms_cnt   <= '0;
      end else if (clr_cnt || !counting) begin
         tick_cnt <= '0;
         ms_cnt   <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
         ms_cnt   <= ms_cnt + MW'(1);
      end else begin
         tick_cnt <= tick_cnt + TW'(1);
      end
   end

   // Next-state, index and buzzer drive selection; keypad overrides the melody.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path
      // leaves one unassigned, which would infer a latch.
      state_d  = state;
      idx_d    = idx;
      clr_cnt  = 1'b0;
      done_d   = 1'b0;
      tone_d   = 2'b00;
      unable_d = 3'b111;

      case (state)
         S_IDLE: begin
            if (play_start && !play_stop) begin
               state_d = S_NOTE;
               idx_d   = '0;
            end
         end

         S_NOTE: begin
            if (play_stop) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else if (key_valid) begin
               state_d = S_PAUSE;
            end else if (cur_entry.tone == 2'b00) begin
`ifdef LOOP_EN
               if (idx != '0) begin
                  idx_d = '0;
               end else begin
                  state_d = S_IDLE;
                  done_d  = 1'b1;
               end
`else
               state_d = S_IDLE;
               done_d  = 1'b1;
`endif
            end else begin
               tone_d   = cur_entry.tone;
               unable_d = cur_entry.note;
               if (phase_end) begin
                  state_d = S_GAP;
               end
            end
         end

         S_GAP: begin
            if (play_stop) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else if (key_valid) begin
               state_d = S_PAUSE;
            end else begin
               // Silent gap keeps the tone but releases the note so a repeated
               // identical note re-sounds.
               tone_d = cur_entry.tone;
               if (phase_end) begin
                  if (idx == AW'(SONG_LEN - 1)) begin
`ifdef LOOP_EN
                     state_d = S_NOTE;
                     idx_d   = '0;
`else
                     state_d = S_IDLE;
                     done_d  = 1'b1;
`endif
                  end else begin
                     state_d = S_NOTE;
                     idx_d   = idx + AW'(1);
                  end
               end
            end
         end

         S_PAUSE: begin
            if (play_stop) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end else if (!key_valid) begin
               state_d = S_NOTE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (state_d != state || idx_d != idx) begin
         clr_cnt = 1'b1;
      end

      if (key_valid) begin
         tone_d   = key_tone;
         unable_d = key_note;
      end
   end

   // Registered buzzer drive and status outputs.
   always_ff @(posedge sysclk) begin
      if (rst) begin
         tone   <= 2'b00;
         unable <= 3'b111;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         tone   <= tone_d;
         unable <= unable_d;
         busy   <= (state_d != S_IDLE);
         done   <= done_d;
      end
   end

endmodule

// File: tb/tb_buzzer_seq.sv
// tb_buzzer_seq: self-checking bench for buzzer_seq with a cycle-count
// reference model (durations in clock cycles from the note/gap rules).
module tb_buzzer_seq;

   localparam int CLK_HZ   = 10000;
   localparam int NOTE_MS  = 4;
   localparam int GAP_MS   = 2;
   localparam int SONG_LEN = 8;
   localparam int AW       = 3;
   localparam int TICK_CYC = CLK_HZ / 1000;
   localparam int GAP_CYC  = GAP_MS * TICK_CYC;

   logic          sysclk = 1'b0;
   logic          rst;
   logic          key_valid;
   logic [2:0]    key_note;
   logic [1:0]    key_tone;
   logic          play_start;
   logic          play_stop;
   logic          cfg_we;
   logic [AW-1:0] cfg_addr;
   logic [6:0]    cfg_data;
   logic [1:0]    tone;
   logic [2:0]    unable;
   logic          busy;
   logic          done;

   int n_cmp = 0;
   int n_bad = 0;

   buzzer_seq #(
      .CLK_HZ   (CLK_HZ),
      .NOTE_MS  (NOTE_MS),
      .GAP_MS   (GAP_MS),
      .SONG_LEN (SONG_LEN)
   ) dut (
      .sysclk     (sysclk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_note   (key_note),
      .key_tone   (key_tone),
      .play_start (play_start),
      .play_stop  (play_stop),
      .cfg_we     (cfg_we),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .tone       (tone),
      .unable     (unable),
      .busy       (busy),
      .done       (done)
   );

   always #5 sysclk = ~sysclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {M_IDLE, M_NOTE, M_GAP, M_PAUSE} mphase_t;

   mphase_t    m_ph = M_IDLE;
   int         m_idx = 0;
   int         m_el = 0;
   logic [6:0] m_tab [SONG_LEN];
   logic [1:0] m_tone = 2'b00;
   logic [2:0] m_unable = 3'b111;
   logic       m_busy = 1'b0;
   logic       m_done = 1'b0;

   function automatic int note_cyc(input logic [6:0] e);
      return (int'(e[1:0]) + 1) * NOTE_MS * TICK_CYC;
   endfunction

   task automatic model_step();
      logic [6:0] e;
      logic [1:0] dt;
      logic [2:0] du;
      mphase_t    np;
      int         ni;
      int         nel;
      bit         nd;
      if (rst) begin
         m_ph = M_IDLE; m_idx = 0; m_el = 0;
         foreach (m_tab[i]) m_tab[i] = '0;
         m_tone = 2'b00; m_unable = 3'b111; m_busy = 1'b0; m_done = 1'b0;
         return;
      end
      e = m_tab[m_idx];
      dt = 2'b00; du = 3'b111;
      np = m_ph; ni = m_idx; nel = m_el + 1; nd = 1'b0;
      case (m_ph)
         M_IDLE: if (play_start && !play_stop) begin np = M_NOTE; ni = 0; end
         M_NOTE: begin
            if (play_stop) begin np = M_IDLE; nd = 1'b1; end
            else if (key_valid) np = M_PAUSE;
            else if (e[6:5] == 2'b00) begin
`ifdef LOOP_EN
               if (m_idx != 0) begin ni = 0; nel = 0; end
               else begin np = M_IDLE; nd = 1'b1; end
`else
               np = M_IDLE; nd = 1'b1;
`endif
            end else begin
               dt = e[6:5]; du = e[4:2];
               if (m_el == note_cyc(e) - 1) np = M_GAP;
            end
         end
         M_GAP: begin
            if (play_stop) begin np = M_IDLE; nd = 1'b1; end
            else if (key_valid) np = M_PAUSE;
            else begin
               dt = e[6:5];
               if (m_el == GAP_CYC - 1) begin
                  if (m_idx == SONG_LEN - 1) begin
`ifdef LOOP_EN
                     np = M_NOTE; ni = 0;
`else
                     np = M_IDLE; nd = 1'b1;
`endif
                  end else begin
                     np = M_NOTE; ni = m_idx + 1;
                  end
               end
            end
         end
         M_PAUSE: begin
            if (play_stop) begin np = M_IDLE; nd = 1'b1; end
            else if (!key_valid) np = M_NOTE;
         end
         default: ;
      endcase
      if (np != m_ph) nel = 0;
      if (key_valid) begin dt = key_tone; du = key_note; end
      if (m_ph == M_IDLE && cfg_we) m_tab[cfg_addr] = cfg_data;
      m_ph = np; m_idx = ni; m_el = nel;
      m_tone = dt; m_unable = du; m_busy = (np != M_IDLE); m_done = nd;
   endtask

   // One clock: model follows the edge, DUT is compared on the falling edge.
   task automatic cycle();
      @(posedge sysclk);
      model_step();
      @(negedge sysclk);
      check("cycle_out", {25'd0, tone, unable, busy, done},
            {25'd0, m_tone, m_unable, m_busy, m_done});
   endtask

   function automatic logic [6:0] rnd_entry();
      return {2'($urandom_range(1, 3)), 3'($urandom_range(0, 6)), 2'($urandom_range(0, 3))};
   endfunction

   task automatic write_entry(input int a, input logic [6:0] d);
      cfg_we = 1'b1; cfg_addr = AW'(a); cfg_data = d;
      cycle();
      cfg_we = 1'b0;
   endtask

   task automatic play_and_measure(input string tag, input int exp_busy, input int budget);
      int nb;
      bit seen;
      seen = 1'b0;
      play_start = 1'b1;
      cycle();
      play_start = 1'b0;
      check({tag, "_busy_rise"}, 32'(busy), 32'd1);
      nb = int'(busy);
      for (int i = 0; i < budget && !seen; i++) begin
         cycle();
         if (done) seen = 1'b1;
         else if (busy) nb++;
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
      check({tag, "_busy_len"}, nb, exp_busy);
      cycle();
      check({tag, "_done_width"}, 32'(done), 32'd0);
   endtask

   task automatic wait_model(input mphase_t ph, input int min_el, input int idx_req,
                             input int budget, input string tag);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         cycle();
         if (m_ph == ph && m_el >= min_el && (idx_req < 0 || m_idx == idx_req)) hit = 1'b1;
      end
      check({tag, "_reached"}, 32'(hit), 32'd1);
   endtask

   task automatic wait_done(input int budget, input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         cycle();
         if (done) seen = 1'b1;
      end
      check({tag, "_done_seen"}, 32'(seen), 32'd1);
   endtask

   logic [6:0] ent [SONG_LEN];

   initial begin
      int nn, ng, exp_b;
      bit seen;

      rst = 1'b1; key_valid = 1'b0; key_note = 3'd0; key_tone = 2'd0;
      play_start = 1'b0; play_stop = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      cycle();
      cycle();
      check("reset_out", {25'd0, tone, unable, busy, done}, {25'd0, 2'b00, 3'b111, 1'b0, 1'b0});
      rst = 1'b0;
      cycle();

      // Keypad path while idle.
      key_valid = 1'b1; key_note = 3'b011; key_tone = 2'b01;
      cycle();
      check("idle_key", {27'd0, tone, unable}, {27'd0, 2'b01, 3'b011});
      key_valid = 1'b0;
      cycle();
      check("idle_key_rel", {27'd0, tone, unable}, {27'd0, 2'b00, 3'b111});

      // 1: single note, then end marker.
      write_entry(0, {2'b11, 3'b000, 2'b01});
      write_entry(1, 7'd0);
      play_start = 1'b1;
      cycle();
      play_start = 1'b0;
      check("t1_busy", 32'(busy), 32'd1);
      nn = 0; ng = 0; seen = 1'b0;
      for (int i = 0; i < 300 && !seen; i++) begin
         cycle();
         if (done) seen = 1'b1;
         else if (tone == 2'b11 && unable == 3'b000) nn++;
         else if (tone == 2'b11 && unable == 3'b111) ng++;
      end
      check("t1_done_seen", 32'(seen), 32'd1);
      check("t1_note_cycles", nn, 80);
      check("t1_gap_cycles", ng, 20);
      check("t1_end_state", {30'd0, busy, tone == 2'b00}, {30'd0, 1'b0, 1'b1});
      cycle();
      check("t1_done_width", 32'(done), 32'd0);

      // 2: key interrupts entry 1; entry 1 replays in full.
      for (int i = 0; i < 3; i++) begin
         ent[i] = rnd_entry();
         write_entry(i, ent[i]);
      end
      write_entry(3, 7'd0);
      play_start = 1'b1;
      cycle();
      play_start = 1'b0;
      wait_model(M_NOTE, 10, 1, 600, "t2_wait");
      key_valid = 1'b1; key_note = 3'b101; key_tone = 2'b10;
      cycle();
      check("t2_key_out", {27'd0, tone, unable}, {27'd0, 2'b10, 3'b101});
      for (int i = 0; i < int'($urandom_range(3, 30)); i++) cycle();
      check("t2_busy_held", 32'(busy), 32'd1);
      key_valid = 1'b0;
      nn = 0;
      for (int i = 0; i < 400; i++) begin
         cycle();
         if ({tone, unable} == {ent[1][6:5], ent[1][4:2]}) nn++;
         else if (nn > 0) break;
      end
      check("t2_replay_len", nn, note_cyc(ent[1]));
      wait_done(800, "t2");

      // 3: stop mid-note with a simultaneous start.
      play_start = 1'b1;
      cycle();
      play_start = 1'b0;
      wait_model(M_NOTE, 30, -1, 200, "t3_wait");
      play_stop = 1'b1; play_start = 1'b1;
      cycle();
      check("t3_stop", {25'd0, tone, unable, busy, done}, {25'd0, 2'b00, 3'b111, 1'b0, 1'b1});
      play_stop = 1'b0; play_start = 1'b0;
      cycle();
      check("t3_idle", {30'd0, busy, done}, 32'd0);
      play_stop = 1'b1; play_start = 1'b1;
      cycle();
      play_stop = 1'b0; play_start = 1'b0;
      check("t3_idle_stopstart", {30'd0, busy, done}, 32'd0);

      // 4: write while busy is ignored.
      play_start = 1'b1;
      cycle();
      play_start = 1'b0;
      for (int i = 0; i < 5; i++) cycle();
      cfg_we = 1'b1; cfg_addr = 3'd3; cfg_data = 7'b1111111;
      cycle();
      cfg_we = 1'b0;
      wait_done(1200, "t4_first");
      cycle();
      exp_b = 1;
      for (int i = 0; i < 3; i++) exp_b += note_cyc(ent[i]) + GAP_CYC;
      play_and_measure("t4", exp_b, 1200);

      // 5: full table, index wrap.
      exp_b = 0;
      for (int i = 0; i < SONG_LEN; i++) begin
         ent[i] = rnd_entry();
         write_entry(i, ent[i]);
         exp_b += note_cyc(ent[i]) + GAP_CYC;
      end
`ifdef LOOP_EN
      play_start = 1'b1;
      cycle();
      play_start = 1'b0;
      nn = 0;
      for (int i = 0; i < exp_b + 100; i++) begin
         cycle();
         if (done) nn++;
      end
      check("t5_loop_no_done", nn, 0);
      check("t5_loop_busy", 32'(busy), 32'd1);
      play_stop = 1'b1;
      cycle();
      play_stop = 1'b0;
      check("t5_loop_stop", {30'd0, busy, done}, 32'd1);
`else
      play_and_measure("t5", exp_b, 3000);
`endif

      // 6: reset during a gap clears everything, including the table.
      play_start = 1'b1;
      cycle();
      play_start = 1'b0;
      wait_model(M_GAP, 3, -1, 400, "t6_wait");
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("t6_rst", {25'd0, tone, unable, busy, done}, {25'd0, 2'b00, 3'b111, 1'b0, 1'b0});
      play_start = 1'b1;
      cycle();
      play_start = 1'b0;
      check("t6_busy", 32'(busy), 32'd1);
      cycle();
      check("t6_done", {30'd0, busy, done}, 32'd1);

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         rst        = ($urandom_range(0, 1499) == 0);
         play_start = ($urandom_range(0, 149) == 0);
         play_stop  = ($urandom_range(0, 599) == 0);
         cfg_we     = ($urandom_range(0, 19) == 0);
         cfg_addr   = AW'($urandom_range(0, SONG_LEN - 1));
         cfg_data   = ($urandom_range(0, 3) == 0) ? 7'(0) : rnd_entry();
         if ($urandom_range(0, 99) < 2) key_valid = ~key_valid;
         if (key_valid && $urandom_range(0, 9) == 0) begin
            key_note = 3'($urandom_range(0, 7));
            key_tone = 2'($urandom_range(0, 3));
         end
         cycle();
      end
      rst = 1'b0; play_start = 1'b0; cfg_we = 1'b0; key_valid = 1'b0;
      play_stop = 1'b1;
      cycle();
      play_stop = 1'b0;
      cycle();
      check("final_idle", 32'(busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/buzzer_seq.md
Name: buzzer_seq

Overview:
Melody sequencer and access arbiter for the buzzer tone generator. It owns the buzzer's tone[1:0]/unable[2:0] inputs and shares them between two requesters: live keypad notes, which have priority, and a stored melody held in a small writable note table. It sits between the keypad/control logic and the buzzer and runs in the 50 MHz sysclk domain.

Parameters:
CLK_HZ, 50000000, sysclk frequency; TICK_DIV = CLK_HZ/1000 gives the 1 ms tick.
NOTE_MS, 250, duration unit in ms; note duration = (len+1)*NOTE_MS.
GAP_MS, 20, silent gap in ms inserted after every melody note.
SONG_LEN, 8, note table depth; power of 2, range 2..16; AW = log2(SONG_LEN).

Ports:
sysclk  in  1  clock.
rst  in  1  reset; synchronous, active-high, sampled on posedge sysclk.
key_valid  in  1  keypad note held.
key_note  in  3  keypad note code 0..6; 7 = silent.
key_tone  in  2  keypad octave: 01 low, 10 mid, 11 high, 00 mute.
play_start  in  1  one-cycle pulse: start melody from entry 0.
play_stop  in  1  one-cycle pulse: abort melody.
cfg_we  in  1  note-table write strobe.
cfg_addr  in  AW  table index.
cfg_data  in  7  entry {tone[6:5], note[4:2], len[1:0]}.
tone  out  2  to buzzer tone.
unable  out  3  to buzzer note input.
busy  out  1  melody active (NOTE, GAP or PAUSE).
done  out  1  one-cycle pulse when the melody ends or is stopped.

Behaviour:
- Reset: tone=00, unable=3'b111, busy=0, done=0, state=IDLE, index=0, tick counter=0, ms counter=0. All table entries cleared to 0, which is the end marker.
- Tick: a free-running counter counts 0..TICK_DIV-1. The tick pulse is asserted on the wrap. It is held at 0 in IDLE and in PAUSE.
- Table writes: cfg_we is accepted only in IDLE and writes the entry at the next edge. Writes in any other state are ignored. An entry with tone==00 is the end marker.
- IDLE: outputs follow the key path. On play_start, go to NOTE with index=0; busy rises on the next edge.
- NOTE: load the entry at the current index. If its tone==00, or the index has passed SONG_LEN-1, end the melody.
  - Otherwise drive tone/unable from the entry and count (len+1)*NOTE_MS ticks, then go to GAP.
- GAP: drive unable=3'b111 and tone=entry tone for GAP_MS ticks. Then increment the index and return to NOTE. The index wraps modulo SONG_LEN; on wrap, end the melody.
  - The gap also re-arms the buzzer so that repeated identical notes re-sound.
- PAUSE: entered from NOTE or GAP when key_valid=1. The ms counter is cleared.
  - When key_valid falls, return to NOTE at the same index. The interrupted note restarts in full.
- End of melody: go to IDLE, busy=0, done=1 for exactly 1 cycle.
- Key arbitration: key_valid=1 always overrides melody outputs, in any state.
  - Output is tone=key_tone, unable=key_note, registered, 1-cycle latency.
  - key_valid=0 in IDLE gives tone=00, unable=3'b111.
- play_stop: from any busy state, go to IDLE next edge and pulse done. In IDLE it has no effect.
  - play_stop and play_start in the same cycle: stop wins, and the block stays or returns to IDLE.
- play_start while busy is ignored. cfg_we and play_start in the same IDLE cycle: the write completes and the start also proceeds; entry 0 is read after the write.
- rst mid-melody: immediate return to reset values. No done pulse. The table is cleared.

Optional Feature:
LOOP_EN:
- Defined: reaching an end marker or wrapping the index restarts at index 0 without a done pulse. Only play_stop ends playback, and an end marker at entry 0 ends normally to avoid a silent loop.
- Undefined: single-shot playback as described above.

Test Plan:
1. CLK_HZ=10000, NOTE_MS=4, GAP_MS=2. Write entry0={11,000,01} and entry1=0, then pulse play_start.
   -> busy=1 next cycle; unable=000, tone=11 for 80 cycles; unable=111 for 20 cycles; then done pulse and busy=0.
2. Play a 3-entry melody; assert key_valid with key_note=101, key_tone=10 during entry1.
   -> Next cycle unable=101, tone=10; on release, entry1 replays its full duration, then entry2 plays.
3. Pulse play_stop mid-note.
   -> Next edge: unable=111, tone=00, busy=0, one-cycle done; a same-cycle play_start is ignored.
4. cfg_we to entry 3 while busy.
   -> Entry unchanged; a re-read after the melody ends shows the old value.
5. Fill all SONG_LEN=8 entries non-zero.
   -> The melody plays 8 notes and 8 gaps, then done (index wrap); with LOOP_EN, entry0 replays and there is no done.
6. Assert rst during GAP.
   -> Next edge: all outputs at reset values and no done; a subsequent play_start immediately ends with a done pulse, because the table is cleared.
